// File: rtl/sync_timing_tracker_pkg.sv
// Shared types and default 640x480@60 timing constants for the sync timing tracker.
package sync_timing_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACKING = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    localparam int VGA_TOTAL_COLS  = 800;
    localparam int VGA_TOTAL_ROWS  = 525;
    localparam int VGA_ACTIVE_COLS = 640;
    localparam int VGA_ACTIVE_ROWS = 480;
    localparam int VGA_COL_W       = 10;
    localparam int VGA_ROW_W       = 10;
    localparam int DEF_FRAME_W     = 8;
    localparam int DEF_LOCK_FRAMES = 4;

    // Good-frame counter width; LOCK_FRAMES is limited to 1..15.
    localparam int GOOD_W = 4;

endpackage

// File: rtl/sync_timing_tracker_if.sv
// Sync inputs and derived timing outputs of the tracker, bundled for port connection.
interface sync_timing_tracker_if
    import sync_timing_pkg::*;
#(
    parameter int COL_W   = VGA_COL_W,
    parameter int ROW_W   = VGA_ROW_W,
    parameter int FRAME_W = DEF_FRAME_W
) ();

    logic               i_HSync;
    logic               i_VSync;
    logic               o_HSync;
    logic               o_VSync;
    logic [COL_W-1:0]   o_Col_Count;
    logic [ROW_W-1:0]   o_Row_Count;
    logic               o_Active;
    logic               o_Line_Start;
    logic               o_Frame_Start;
    logic [FRAME_W-1:0] o_Frame_Count;
    logic               o_Locked;
    logic               o_Lock_Lost;

    // Master: the sync source / consumer side.
    modport master (
        output i_HSync, i_VSync,
        input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
               o_Line_Start, o_Frame_Start, o_Frame_Count, o_Locked, o_Lock_Lost
    );

    // Slave: the tracker itself.
    modport slave (
        input  i_HSync, i_VSync,
        output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
               o_Line_Start, o_Frame_Start, o_Frame_Count, o_Locked, o_Lock_Lost
    );

endinterface

// File: rtl/sync_timing_tracker_lock.sv
// Lock detector: counts consecutive VSync edges that land exactly on the frame wrap.
module sync_lock_fsm
    import sync_timing_pkg::*;
#(
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Edge,
    input  logic i_At_Wrap,
    input  logic i_Nat_Wrap,
    output logic o_Locked,
    output logic o_Lock_Lost
);

    localparam logic [GOOD_W-1:0] GOOD_TARGET = LOCK_FRAMES[GOOD_W-1:0];
    localparam logic [GOOD_W-1:0] GOOD_ONE    = {{(GOOD_W-1){1'b0}}, 1'b1};

    lock_state_e       r_State;
    lock_state_e       w_State_Next;
    logic [GOOD_W-1:0] r_Good;
    logic [GOOD_W-1:0] w_Good_Next;
    logic [GOOD_W-1:0] w_Good_Inc;
    logic              r_Lost;
    logic              w_Lost_Next;
    logic              w_Good_Frame;
    logic              w_Bad_Frame;

    // An edge off the wrap point, or a wrap with no edge, both break the cadence.
    assign w_Good_Frame = i_Edge & i_At_Wrap;
    assign w_Bad_Frame  = (i_Edge & ~i_At_Wrap) | i_Nat_Wrap;
    assign w_Good_Inc   = r_Good + GOOD_ONE;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= UNLOCKED;
            r_Good  <= '0;
            r_Lost  <= 1'b0;
        end else begin
            r_State <= w_State_Next;
            r_Good  <= w_Good_Next;
            r_Lost  <= w_Lost_Next;
        end
    end

    always_comb begin
        w_State_Next = r_State;
        w_Good_Next  = r_Good;
        w_Lost_Next  = 1'b0;
        case (r_State)
            UNLOCKED: begin
                if (i_Edge) begin
                    w_State_Next = TRACKING;
                    w_Good_Next  = '0;
                end
            end
            TRACKING: begin
                if (w_Good_Frame) begin
                    w_Good_Next = w_Good_Inc;
                    if (w_Good_Inc == GOOD_TARGET) begin
                        w_State_Next = LOCKED;
                    end
                end else if (w_Bad_Frame) begin
                    w_Good_Next = '0;
                end
            end
            LOCKED: begin
                if (w_Bad_Frame) begin
                    w_State_Next = TRACKING;
                    w_Good_Next  = '0;
                    w_Lost_Next  = 1'b1;
                end
            end
            default: begin
                w_State_Next = UNLOCKED;
                w_Good_Next  = '0;
            end
        endcase
    end

    assign o_Locked    = (r_State == LOCKED);
    assign o_Lock_Lost = r_Lost;

endmodule

// File: rtl/sync_timing_tracker.sv
// Regenerates row/column position, active/start flags, frame count and lock status
// from incoming HSync/VSync; all outputs are registered one cycle behind the syncs.
module sync_timing_tracker
    import sync_timing_pkg::*;
#(
    parameter int TOTAL_COLS      = VGA_TOTAL_COLS,
    parameter int TOTAL_ROWS      = VGA_TOTAL_ROWS,
    parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
    parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
    parameter int COL_W           = VGA_COL_W,
    parameter int ROW_W           = VGA_ROW_W,
    parameter int SYNC_ACTIVE_LOW = 0,
    parameter int FRAME_W         = DEF_FRAME_W,
    parameter int LOCK_FRAMES     = DEF_LOCK_FRAMES
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    sync_timing_tracker_if.slave  bus
);

    localparam int COL_LAST_I = TOTAL_COLS - 1;
    localparam int ROW_LAST_I = TOTAL_ROWS - 1;

    localparam logic [COL_W-1:0]   COL_LAST  = COL_LAST_I[COL_W-1:0];
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_LAST_I[ROW_W-1:0];
    localparam logic [COL_W:0]     COL_ACT   = ACTIVE_COLS[COL_W:0];
    localparam logic [ROW_W:0]     ROW_ACT   = ACTIVE_ROWS[ROW_W:0];
    localparam logic [COL_W-1:0]   COL_ONE   = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]   ROW_ONE   = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};
    localparam logic               INACT     = (SYNC_ACTIVE_LOW != 0);

    logic               r_HSync;
    logic               r_VSync;
    logic               r_Armed;
    logic [COL_W-1:0]   r_Col;
    logic [ROW_W-1:0]   r_Row;
    logic               r_Active;
    logic               r_Line_Start;
    logic               r_Frame_Start;
    logic [FRAME_W-1:0] r_Frame;

    logic               w_V;
    logic               w_V_Prev;
    logic               w_Edge;
    logic               w_Col_End;
    logic               w_Row_End;
    logic               w_At_Wrap;
    logic               w_Nat_Wrap;
    logic [COL_W-1:0]   w_Col_Next;
    logic [ROW_W-1:0]   w_Row_Next;
    logic               w_Active_Next;
    logic               w_Locked;
    logic               w_Lock_Lost;

    // Syncs are normalised to active-high; the delayed copy doubles as the edge history.
    assign w_V      = bus.i_VSync ^ INACT;
    assign w_V_Prev = r_VSync ^ INACT;

    // r_Armed blocks edges until VSync has been seen inactive since reset, so a sync
    // held active across reset release does not count as a new frame.
    assign w_Edge   = w_V & ~w_V_Prev & r_Armed;

    assign w_Col_End  = (r_Col == COL_LAST);
    assign w_Row_End  = (r_Row == ROW_LAST);
    assign w_At_Wrap  = w_Col_End & w_Row_End;
    assign w_Nat_Wrap = w_At_Wrap & ~w_Edge;

    always_comb begin
        w_Col_Next = r_Col + COL_ONE;
        w_Row_Next = r_Row;
        if (w_Edge) begin
            w_Col_Next = '0;
            w_Row_Next = '0;
        end else if (w_Col_End) begin
            w_Col_Next = '0;
            w_Row_Next = w_Row_End ? '0 : (r_Row + ROW_ONE);
        end
    end

    assign w_Active_Next = ({1'b0, w_Col_Next} < COL_ACT) && ({1'b0, w_Row_Next} < ROW_ACT);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_HSync       <= INACT;
            r_VSync       <= INACT;
            r_Armed       <= 1'b0;
            r_Col         <= '0;
            r_Row         <= '0;
            r_Active      <= 1'b0;
            r_Line_Start  <= 1'b0;
            r_Frame_Start <= 1'b0;
            r_Frame       <= '0;
        end else begin
            r_HSync       <= bus.i_HSync;
            r_VSync       <= bus.i_VSync;
            r_Armed       <= r_Armed | ~w_V;
            r_Col         <= w_Col_Next;
            r_Row         <= w_Row_Next;
            r_Active      <= w_Active_Next;
            r_Line_Start  <= w_Edge | w_Col_End;
            r_Frame_Start <= w_Edge;
            if (w_Edge) begin
                r_Frame <= r_Frame + FRAME_ONE;
            end
        end
    end

    sync_lock_fsm #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Edge      (w_Edge),
        .i_At_Wrap   (w_At_Wrap),
        .i_Nat_Wrap  (w_Nat_Wrap),
        .o_Locked    (w_Locked),
        .o_Lock_Lost (w_Lock_Lost)
    );

    assign bus.o_HSync       = r_HSync;
    assign bus.o_VSync       = r_VSync;
    assign bus.o_Col_Count   = r_Col;
    assign bus.o_Row_Count   = r_Row;
    assign bus.o_Active      = r_Active;
    assign bus.o_Line_Start  = r_Line_Start;
    assign bus.o_Frame_Start = r_Frame_Start;
    assign bus.o_Frame_Count = r_Frame;
    assign bus.o_Locked      = w_Locked;
    assign bus.o_Lock_Lost   = w_Lock_Lost;

endmodule

// File: tb/tb_sync_timing_tracker.sv
// Drives a small-raster sync pattern into active-high and active-low trackers and
// scores every output cycle against a position/lock reference model.
module tb_sync_timing_tracker;

    localparam int TC    = 20;
    localparam int TR    = 12;
    localparam int AC    = 16;
    localparam int AR    = 9;
    localparam int CW    = 5;
    localparam int RW    = 4;
    localparam int FW    = 8;
    localparam int LF    = 4;
    localparam int FRAME = TC * TR;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          act;
        logic          ls;
        logic          fs;
        logic [FW-1:0] fc;
        logic          lk;
        logic          lost;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    // Reference state: linear position in frame, delayed syncs, lock bookkeeping.
    int m_pos, m_fc, m_st, m_good;
    bit m_vd, m_armed;

    always #5 clk = ~clk;

    sync_timing_tracker_if #(.COL_W(CW), .ROW_W(RW), .FRAME_W(FW)) bus_h ();
    sync_timing_tracker_if #(.COL_W(CW), .ROW_W(RW), .FRAME_W(FW)) bus_l ();

    sync_timing_tracker #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .COL_W(CW), .ROW_W(RW), .SYNC_ACTIVE_LOW(0), .FRAME_W(FW), .LOCK_FRAMES(LF)
    ) u_dut_h (.i_Clk(clk), .i_Reset(rst), .bus(bus_h));

    sync_timing_tracker #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .COL_W(CW), .ROW_W(RW), .SYNC_ACTIVE_LOW(1), .FRAME_W(FW), .LOCK_FRAMES(LF)
    ) u_dut_l (.i_Clk(clk), .i_Reset(rst), .bus(bus_l));

    function automatic obs_t grab_h();
        obs_t o;
        o.hs = bus_h.o_HSync;       o.vs = bus_h.o_VSync;
        o.col = bus_h.o_Col_Count;  o.row = bus_h.o_Row_Count;
        o.act = bus_h.o_Active;     o.ls = bus_h.o_Line_Start;
        o.fs = bus_h.o_Frame_Start; o.fc = bus_h.o_Frame_Count;
        o.lk = bus_h.o_Locked;      o.lost = bus_h.o_Lock_Lost;
        return o;
    endfunction

    function automatic obs_t grab_l();
        obs_t o;
        o.hs = bus_l.o_HSync;       o.vs = bus_l.o_VSync;
        o.col = bus_l.o_Col_Count;  o.row = bus_l.o_Row_Count;
        o.act = bus_l.o_Active;     o.ls = bus_l.o_Line_Start;
        o.fs = bus_l.o_Frame_Start; o.fc = bus_l.o_Frame_Count;
        o.lk = bus_l.o_Locked;      o.lost = bus_l.o_Lock_Lost;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dcheck(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the reference by one clock for active-high sync levels hs/vs.
    task automatic model_step(input bit hs, input bit vs);
        obs_t e;
        bit   edge_s, wrap, lost;
        e = '0;
        if (rst) begin
            m_pos = 0; m_fc = 0; m_st = 0; m_good = 0; m_vd = 0; m_armed = 0;
        end else begin
            edge_s = vs && !m_vd && m_armed;
            wrap   = (m_pos == FRAME - 1);
            lost   = 0;
            if (m_st == 0) begin
                if (edge_s) begin m_st = 1; m_good = 0; end
            end else if (m_st == 1) begin
                if (edge_s && wrap) begin
                    m_good++;
                    if (m_good == LF) m_st = 2;
                end else if (edge_s || wrap) begin
                    m_good = 0;
                end
            end else begin
                if (edge_s != wrap) begin m_st = 1; m_good = 0; lost = 1; end
            end
            if (!vs) m_armed = 1;
            m_pos = edge_s ? 0 : (m_pos + 1) % FRAME;
            if (edge_s) m_fc = (m_fc + 1) % (1 << FW);
            m_vd   = vs;
            e.hs   = hs;
            e.vs   = vs;
            e.col  = CW'(m_pos % TC);
            e.row  = RW'(m_pos / TC);
            e.act  = ((m_pos % TC) < AC) && ((m_pos / TC) < AR);
            e.ls   = ((m_pos % TC) == 0);
            e.fs   = edge_s;
            e.fc   = FW'(m_fc);
            e.lk   = (m_st == 2);
            e.lost = lost;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit hs, input bit vs);
        obs_t e;
        bus_h.i_HSync = hs;  bus_h.i_VSync = vs;
        bus_l.i_HSync = ~hs; bus_l.i_VSync = ~vs;
        model_step(hs, vs);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cyc_hi", grab_h(), e);
        e.hs = ~e.hs;
        e.vs = ~e.vs;
        check("cyc_lo", grab_l(), e);
    endtask

    // Raster indices first..last-1 of one frame; VSync covers the first two lines.
    task automatic frame(input int first, input int last, input bit vs_on, input bit chk);
        bit hs, vs;
        for (int i = first; i < last; i++) begin
            vs = vs_on && (i < 2 * TC);
            hs = (i % TC) < 3;
            tick(hs, vs);
            if (chk) begin
                if (i == 0)
                    dcheck("vs_align", {bus_h.o_VSync, 3'b0, bus_h.o_Col_Count, 3'b0, bus_h.o_Row_Count},
                           {1'b1, 3'b0, 5'd0, 3'b0, 4'd0});
                if (i / TC == 0 && i % TC == AC - 1) dcheck("act_last_col", bus_h.o_Active, 1);
                if (i / TC == 0 && i % TC == AC)     dcheck("act_first_blank", bus_h.o_Active, 0);
                if (i / TC == AR)                    dcheck("act_blank_row", bus_h.o_Active, 0);
            end
        end
    endtask

    initial begin
        bus_h.i_HSync = 1'b0; bus_h.i_VSync = 1'b0;
        bus_l.i_HSync = 1'b1; bus_l.i_VSync = 1'b1;

        // Reset state
        tick(0, 0);
        tick(0, 0);
        dcheck("rst_vs_low", bus_l.o_VSync, 1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(0, 0);

        // Clean timing: lock on the 5th edge, six edges counted
        for (int k = 1; k <= 6; k++) begin
            frame(0, FRAME, 1, 1);
            dcheck("clean_fc", bus_h.o_Frame_Count, k);
            dcheck("clean_lock", bus_h.o_Locked, (k >= 1 + LF) ? 1 : 0);
        end

        // VSync edge three cycles early
        frame(0, FRAME - 3, 1, 0);
        frame(0, 1, 1, 0);
        dcheck("early_lost", bus_h.o_Lock_Lost, 1);
        dcheck("early_unlock", bus_h.o_Locked, 0);
        dcheck("early_col0", bus_h.o_Col_Count, 0);
        frame(1, 2, 1, 0);
        dcheck("early_lost_1cyc", bus_h.o_Lock_Lost, 0);
        frame(2, FRAME, 1, 0);
        for (int k = 1; k <= LF; k++) begin
            frame(0, FRAME, 1, 0);
            dcheck("relock", bus_h.o_Locked, (k == LF) ? 1 : 0);
        end

        // Missing VSync pulse: natural wrap drops lock without a frame start
        frame(0, 1, 0, 0);
        dcheck("miss_lost", bus_h.o_Lock_Lost, 1);
        dcheck("miss_fs", bus_h.o_Frame_Start, 0);
        dcheck("miss_fc", bus_h.o_Frame_Count, 12);
        dcheck("miss_pos", {bus_h.o_Col_Count, bus_h.o_Row_Count}, 0);
        frame(1, FRAME, 0, 0);
        for (int k = 1; k <= LF; k++) begin
            frame(0, FRAME, 1, 0);
            dcheck("miss_relock", bus_h.o_Locked, (k == LF) ? 1 : 0);
        end
        dcheck("miss_fc_end", bus_h.o_Frame_Count, 16);

        // Reset mid-frame with VSync held active
        frame(0, 10, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_hi", grab_h(), '0);
        dcheck("rst_async_lo_vs", bus_l.o_VSync, 1);
        frame(10, 13, 1, 0);
        rst = 1'b0;
        frame(13, FRAME, 1, 0);
        dcheck("rst_no_edge_fc", bus_h.o_Frame_Count, 0);
        for (int k = 1; k <= 1 + LF; k++) begin
            frame(0, FRAME, 1, 0);
            dcheck("rst_relock", bus_h.o_Locked, (k == 1 + LF) ? 1 : 0);
        end
        dcheck("rst_relock_fc", bus_h.o_Frame_Count, 1 + LF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_timing_tracker.md
# sync_timing_tracker

Parametrised successor to the team's sync-to-count block: regenerates row/column counters from incoming HSync/VSync, and adds sync polarity selection, active-area and line/frame-start flags, a frame counter, and a lock detector. Sits between the VGA sync generator and any pixel-producing module (pattern, Pong, text overlay) that needs position, validity and "timing is stable" information.

## Interface
- TOTAL_COLS, 800, columns per line including blanking
- TOTAL_ROWS, 525, rows per frame including blanking
- ACTIVE_COLS, 640, visible columns (must be ≤ TOTAL_COLS)
- ACTIVE_ROWS, 480, visible rows (must be ≤ TOTAL_ROWS)
- COL_W, 10, column counter width (2^COL_W ≥ TOTAL_COLS)
- ROW_W, 10, row counter width (2^ROW_W ≥ TOTAL_ROWS)
- SYNC_ACTIVE_LOW, 0, 1 = syncs are active-low
- FRAME_W, 8, frame counter width
- LOCK_FRAMES, 4, consecutive good frames required for lock (1–15)

- i_Clk  in  1  pixel clock; one clock
- i_Reset  in  1  asynchronous, active-high reset
- i_HSync  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- i_VSync  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- o_HSync  out  1  i_HSync delayed one cycle, polarity unchanged
- o_VSync  out  1  i_VSync delayed one cycle, polarity unchanged
- o_Col_Count  out  COL_W  column position aligned to o_HSync/o_VSync
- o_Row_Count  out  ROW_W  row position
- o_Active  out  1  col < ACTIVE_COLS and row < ACTIVE_ROWS
- o_Line_Start  out  1  one-cycle pulse when o_Col_Count becomes 0
- o_Frame_Start  out  1  one-cycle pulse when a VSync edge realigns counters
- o_Frame_Count  out  FRAME_W  VSync edges seen since reset, wraps
- o_Locked  out  1  timing stable
- o_Lock_Lost  out  1  one-cycle pulse on leaving LOCKED

## Operation
- Normalise: v = i_VSync ^ SYNC_ACTIVE_LOW; edge = v & ~v_prev (v_prev = o_VSync normalised).
- On edge: counters load 0, o_Frame_Start=1, o_Line_Start=1, o_Frame_Count+1 (wraps at 2^FRAME_W).
- Otherwise: col increments; at TOTAL_COLS-1 col→0, o_Line_Start=1, row increments; row at TOTAL_ROWS-1 wraps to 0 (natural wrap, no o_Frame_Start).
- HSync does not realign counters; it is only delayed.
- Good frame: edge sampled while col==TOTAL_COLS-1 and row==TOTAL_ROWS-1. Bad frame: edge at any other position, or natural frame wrap with no coincident edge.
- Lock FSM, 4-bit good counter:
  - UNLOCKED: first edge → TRACKING, good=0.
  - TRACKING: good frame → good+1; good reaches LOCK_FRAMES → LOCKED. Bad frame → good=0, stay.
  - LOCKED: good frame → stay. Bad frame → TRACKING, good=0, o_Lock_Lost=1 for one cycle.
- o_Locked = (state == LOCKED).

## Timing
- All outputs registered; o_HSync/o_VSync latency 1 cycle.
- Counters are 0 on the same edge that o_VSync first shows active, matching the existing alignment.
- o_Active, o_Line_Start and o_Frame_Start are computed from next-state counters, so they align with the counter values they describe.
- Reset (async assert, sync release): counters 0, o_Frame_Count 0, flags 0, o_Locked 0, state UNLOCKED. o_HSync, o_VSync and v_prev reset to the inactive level (SYNC_ACTIVE_LOW), so no false edge occurs at release.
- Sync held active across reset release produces no edge until it deasserts and reasserts.
- Reset mid-frame discards lock; re-lock needs 1 + LOCK_FRAMES edges.

## Structure
- Package sync_timing_pkg: lock state enum (UNLOCKED, TRACKING, LOCKED) and 640x480@60 default constants.
- One sub-module, sync_lock_fsm: takes edge, at_wrap, nat_wrap; outputs o_Locked and o_Lock_Lost. Counters stay in the top level.

## Test plan
- Default params, clean 800x525 timing, 6 frames → counters 0 at o_VSync assert; o_Locked rises on 5th edge (1 + LOCK_FRAMES); o_Frame_Count=6.
- At row 0, col 639 → o_Active=1; at col 640 → o_Active=0; at row 480 → o_Active=0 all line.
- After lock, shift one VSync edge 3 cycles early → counters 0 at that edge, o_Lock_Lost one cycle, o_Locked=0, re-locked 4 good frames later.
- After lock, suppress one VSync pulse → at natural wrap (799,524→0,0) o_Lock_Lost pulses, o_Frame_Start stays 0, o_Frame_Count unchanged.
- SYNC_ACTIVE_LOW=1, inverted syncs → identical counter and lock behaviour; o_VSync reads 1 after reset.
- Assert i_Reset mid-frame with i_VSync held active → all outputs reset immediately; no o_Frame_Start until VSync deasserts and reasserts.
